// File: rtl/frame_capture_seq.sv
// Frame-capture sequencer: resets and settles the pixel FIFO, pulses FRAME_REQ to the
// imager, then gates pixel writes and counts pixels per frame across multi-frame bursts.
module frame_capture_seq #(
    parameter int STALL_CYCLES     = 32768,
    parameter int REQ_PULSE_CYCLES = 4,
    parameter int PIXELS_PER_FRAME = 315392,
    parameter int PIX_CNT_W        = 20,
    parameter int FRAMES_W         = 8,
    parameter int TIMEOUT_CYCLES   = 1048575
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_image_req,
    input  logic [FRAMES_W-1:0] num_frames,
    input  logic                abort,
    input  logic                pix_valid,
    input  logic                fifo_full,
    output logic [3:0]          state,
    output logic                frame_req_out,
    output logic                wr_reset,
    output logic                rd_reset,
    output logic                fifo_wr_en,
    output logic                busy,
    output logic                done,
    output logic [FRAMES_W-1:0] frames_done,
    output logic                overflow,
    output logic                timeout_err
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FIFO_RESET = 4'd1;
    localparam logic [3:0] S_STALL_FIFO = 4'd2;
    localparam logic [3:0] S_FRAME_REQ  = 4'd3;
    localparam logic [3:0] S_WAIT_DATA  = 4'd4;
    localparam logic [3:0] S_CAPTURE    = 4'd5;
    localparam logic [3:0] S_DONE       = 4'd6;
    localparam logic [3:0] S_ERROR      = 4'd7;

    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int PULSE_W = $clog2(REQ_PULSE_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [PULSE_W-1:0]   PULSE_LAST = PULSE_W'(REQ_PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PIX_CNT_W-1:0] PIX_LAST   = PIX_CNT_W'(PIXELS_PER_FRAME - 1);

    logic [3:0]           state_next;
    logic                 pc_req_q;
    logic                 req_armed;
    logic                 req_rise;
    logic [STALL_W-1:0]   stall_cnt;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic [FRAMES_W-1:0]  frames_target;
    logic [FRAMES_W:0]    frames_after;
    logic                 more_frames;
    logic                 capturing;
    logic                 pix_hit;
    logic                 frame_end;

    // req_armed blocks a request that was already high when reset was released
    assign req_rise     = pc_image_req & ~pc_req_q & req_armed;
    assign capturing    = (state == S_WAIT_DATA) || (state == S_CAPTURE);
    assign frames_after = {1'b0, frames_done} + (FRAMES_W + 1)'(1);
    assign more_frames  = frames_after < {1'b0, frames_target};
    assign busy         = (state != S_IDLE);
    assign fifo_wr_en   = capturing & pix_valid & ~fifo_full & ~abort;

    always_comb begin
        state_next = state;
        pix_hit    = 1'b0;
        frame_end  = 1'b0;
        if ((state != S_IDLE) && abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (req_rise) state_next = S_FIFO_RESET;
                S_FIFO_RESET: if (!pc_image_req) state_next = S_STALL_FIFO;
                S_STALL_FIFO: if (stall_cnt == STALL_LAST) state_next = S_FRAME_REQ;
                S_FRAME_REQ:  if (pulse_cnt == PULSE_LAST) state_next = S_WAIT_DATA;
                S_WAIT_DATA, S_CAPTURE: begin
                    if (pix_valid) begin
                        pix_hit    = 1'b1;
                        state_next = S_CAPTURE;
                        if (pix_cnt == PIX_LAST) begin
                            frame_end  = 1'b1;
                            state_next = more_frames ? S_FRAME_REQ : S_DONE;
                        end
                    end else if ((state == S_WAIT_DATA) && (tmo_cnt == TMO_LAST)) begin
                        state_next = S_ERROR;
                    end
                end
                S_DONE:       state_next = S_IDLE;
                S_ERROR:      state_next = S_IDLE;
                default:      state_next = S_IDLE;
            endcase
        end
    end

    // Pulse outputs are registered from the next state so they align with the state itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc_req_q      <= 1'b0;
            req_armed     <= 1'b0;
            frame_req_out <= 1'b0;
            wr_reset      <= 1'b0;
            rd_reset      <= 1'b0;
            done          <= 1'b0;
            stall_cnt     <= '0;
            pulse_cnt     <= '0;
            tmo_cnt       <= '0;
            pix_cnt       <= '0;
            frames_target <= '0;
            frames_done   <= '0;
            overflow      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_next;
            pc_req_q      <= pc_image_req;
            if (!pc_image_req) begin
                req_armed <= 1'b1;
            end
            frame_req_out <= (state_next == S_FRAME_REQ);
            wr_reset      <= (state_next == S_FIFO_RESET);
            rd_reset      <= (state_next == S_FIFO_RESET);
            done          <= (state_next == S_DONE);

            stall_cnt <= (state == S_STALL_FIFO) ? stall_cnt + STALL_W'(1) : '0;
            pulse_cnt <= (state == S_FRAME_REQ)  ? pulse_cnt + PULSE_W'(1) : '0;
            tmo_cnt   <= (state == S_WAIT_DATA)  ? tmo_cnt + TMO_W'(1)     : '0;

            if (!capturing || frame_end) begin
                pix_cnt <= '0;
            end else if (pix_hit) begin
                pix_cnt <= pix_cnt + PIX_CNT_W'(1);
            end

            if ((state == S_IDLE) && req_rise) begin
                frames_target <= (num_frames == '0) ? FRAMES_W'(1) : num_frames;
                frames_done   <= '0;
                overflow      <= 1'b0;
                timeout_err   <= 1'b0;
            end else begin
                if (frame_end) begin
                    frames_done <= frames_after[FRAMES_W-1:0];
                end
                if (pix_hit && fifo_full) begin
                    overflow <= 1'b1;
                end
                if ((state == S_WAIT_DATA) && (state_next == S_ERROR)) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_seq.sv
// Self-checking bench for frame_capture_seq: per-scenario tasks with a write-enable
// scoreboard (expected writes queued at drive time, observed writes queued at sample time).
module tb_frame_capture_seq;

    localparam int STALL = 8;
    localparam int PULSE = 4;
    localparam int PPF   = 16;
    localparam int PCW   = 5;
    localparam int FW    = 8;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_image_req = 1'b0;
    logic [FW-1:0] num_frames = '0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic          fifo_full = 1'b0;
    logic [3:0]    state;
    logic          frame_req_out, wr_reset, rd_reset, fifo_wr_en, busy, done;
    logic [FW-1:0] frames_done;
    logic          overflow, timeout_err;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_q[$];
    logic obs_q[$];
    int   mon_wr = 0, mon_req_hi = 0, mon_req_rise = 0, mon_rst_hi = 0, mon_done = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    frame_capture_seq #(
        .STALL_CYCLES(STALL), .REQ_PULSE_CYCLES(PULSE), .PIXELS_PER_FRAME(PPF),
        .PIX_CNT_W(PCW), .FRAMES_W(FW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_image_req(pc_image_req), .num_frames(num_frames),
        .abort(abort), .pix_valid(pix_valid), .fifo_full(fifo_full), .state(state),
        .frame_req_out(frame_req_out), .wr_reset(wr_reset), .rd_reset(rd_reset),
        .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done), .frames_done(frames_done),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    // Event counters sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (fifo_wr_en) mon_wr++;
        if (frame_req_out) mon_req_hi++;
        if (frame_req_out && !req_prev) mon_req_rise++;
        req_prev = frame_req_out;
        if (wr_reset && rd_reset) mon_rst_hi++;
        if (done) mon_done++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, state=%0d", state);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_wr = 0; mon_req_hi = 0; mon_req_rise = 0; mon_rst_hi = 0; mon_done = 0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state === s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic request(input int len, input logic [FW-1:0] nf);
        num_frames   = nf;
        pc_image_req = 1'b1;
        repeat (len) tick();
        pc_image_req = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int full_lo, input int full_hi);
        for (int i = 1; i <= n; i++) begin
            pix_valid = 1'b1;
            fifo_full = (i >= full_lo) && (i <= full_hi);
            exp_q.push_back(!fifo_full);
            @(negedge clk);
            obs_q.push_back(fifo_wr_en);
            tick();
        end
        pix_valid = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        rst_n = 1'b0;
        repeat (3) tick();
        outs = {state, frame_req_out, wr_reset, rd_reset, fifo_wr_en, busy, done,
                frames_done, overflow, timeout_err};
        n_checks++;
        if (outs !== 20'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (state !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: state %0d busy %b want 0 0", state, busy);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int n, idx;
        logic e, o;
        clear_mon();
        request(3, 8'd1);
        wait_state(4'd2, 5, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL single_reach_stall: state %0d want 2", state); end
        n_checks++;
        if (mon_rst_hi !== 3) begin n_fail++; $display("[TB] FAIL single_reset_cycles: got %0d want 3", mon_rst_hi); end
        n = 0;
        while (state === 4'd2 && n < 50) begin tick(); n++; end
        n_checks++;
        if (n !== STALL || state !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL single_stall_len: got %0d cycles then state %0d want %0d then 3", n, state, STALL);
        end
        wait_state(4'd4, 10, ok);
        n_checks++;
        if (!ok || mon_req_hi !== PULSE || mon_req_rise !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_frame_req: high %0d rises %0d want %0d 1", mon_req_hi, mon_req_rise, PULSE);
        end
        send_pixels(PPF, 0, 0);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); idx++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL single_wr_en pixel %0d: got %b want %b", idx, o, e); end
        end
        n_checks++;
        if (state !== 4'd6 || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_done_state: state %0d done %b want 6 1", state, done);
        end
        tick();
        n_checks++;
        if (state !== 4'd0 || done !== 1'b0 || mon_done !== 1 || mon_wr !== PPF || frames_done !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL single_end: state %0d done %b pulses %0d writes %0d frames %0d want 0 0 1 %0d 1",
                     state, done, mon_done, mon_wr, frames_done, PPF);
        end
    endtask

    task automatic test_burst();
        bit ok;
        int idx;
        logic e, o;
        clear_mon();
        request(2, 8'd3);
        for (int f = 0; f < 3; f++) begin
            wait_state(4'd4, 40, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("[TB] FAIL burst_wait_data frame %0d: state %0d want 4", f, state); end
            send_pixels(PPF, 0, 0);
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); idx++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL burst_wr_en pixel %0d: got %b want %b", idx, o, e); end
        end
        n_checks++;
        if (state !== 4'd6) begin n_fail++; $display("[TB] FAIL burst_done_state: got %0d want 6", state); end
        tick();
        n_checks++;
        if (frames_done !== 8'd3 || mon_done !== 1 || mon_req_rise !== 3 || mon_rst_hi !== 2 || mon_wr !== 3 * PPF) begin
            n_fail++;
            $display("[TB] FAIL burst_totals: frames %0d done %0d reqs %0d rst %0d wr %0d want 3 1 3 2 %0d",
                     frames_done, mon_done, mon_req_rise, mon_rst_hi, mon_wr, 3 * PPF);
        end
        clear_mon();
        request(2, 8'd0);
        wait_state(4'd4, 40, ok);
        send_pixels(PPF, 0, 0);
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (!ok || state !== 4'd6) begin n_fail++; $display("[TB] FAIL zero_frames_done: state %0d want 6", state); end
        tick();
        n_checks++;
        if (frames_done !== 8'd1 || mon_done !== 1 || mon_req_rise !== 1) begin
            n_fail++;
            $display("[TB] FAIL zero_frames_totals: frames %0d done %0d reqs %0d want 1 1 1", frames_done, mon_done, mon_req_rise);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int idx;
        logic e, o;
        clear_mon();
        request(3, 8'd1);
        wait_state(4'd4, 40, ok);
        n_checks++;
        if (!ok || overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_start: overflow %b state %0d want 0 4", overflow, state); end
        send_pixels(PPF, 5, 7);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); idx++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL ovf_wr_en pixel %0d: got %b want %b", idx, o, e); end
        end
        n_checks++;
        if (state !== 4'd6 || overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_frame_end: state %0d overflow %b want 6 1", state, overflow);
        end
        tick();
        n_checks++;
        if (mon_wr !== 13 || overflow !== 1'b1 || frames_done !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL ovf_totals: writes %0d overflow %b frames %0d want 13 1 1", mon_wr, overflow, frames_done);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        clear_mon();
        request(2, 8'd1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_ovf_cleared: got %b want 0", overflow); end
        wait_state(4'd4, 40, ok);
        n = 0;
        while (state === 4'd4 && n < 200) begin tick(); n++; end
        n_checks++;
        if (!ok || n !== TMO) begin n_fail++; $display("[TB] FAIL tmo_wait_len: got %0d want %0d", n, TMO); end
        n_checks++;
        if (state !== 4'd7 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL tmo_error: state %0d timeout_err %b want 7 1", state, timeout_err);
        end
        tick();
        n_checks++;
        if (state !== 4'd0 || timeout_err !== 1'b1 || mon_done !== 0) begin
            n_fail++;
            $display("[TB] FAIL tmo_idle: state %0d timeout_err %b done %0d want 0 1 0", state, timeout_err, mon_done);
        end
        request(2, 8'd1);
        n_checks++;
        if (state !== 4'd1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_cleared: state %0d timeout_err %b want 1 0", state, timeout_err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (state !== 4'd0 || wr_reset !== 1'b0 || rd_reset !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_abort_reset: state %0d wr %b rd %b want 0 0 0", state, wr_reset, rd_reset);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int idx;
        logic e, o;
        clear_mon();
        request(3, 8'd1);
        wait_state(4'd4, 40, ok);
        send_pixels(7, 0, 0);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); idx++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL abort_wr_en pixel %0d: got %b want %b", idx, o, e); end
        end
        abort = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fifo_wr_en !== 1'b0 || state !== 4'd5) begin
            n_fail++;
            $display("[TB] FAIL abort_same_cycle: wr_en %b state %0d want 0 5", fifo_wr_en, state);
        end
        tick();
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: state %0d wr_en %b busy %b want 0 0 0", state, fifo_wr_en, busy);
        end
        tick();
        pix_valid = 1'b0;
        n_checks++;
        if (mon_done !== 0 || frames_done !== 8'd0 || mon_wr !== 7) begin
            n_fail++;
            $display("[TB] FAIL abort_totals: done %0d frames %0d writes %0d want 0 0 7", mon_done, frames_done, mon_wr);
        end
        clear_mon();
        request(2, 8'd1);
        wait_state(4'd4, 40, ok);
        send_pixels(PPF, 0, 0);
        exp_q.delete();
        obs_q.delete();
        tick();
        n_checks++;
        if (!ok || mon_done !== 1 || frames_done !== 8'd1 || mon_wr !== PPF) begin
            n_fail++;
            $display("[TB] FAIL abort_rerequest: done %0d frames %0d writes %0d want 1 1 %0d", mon_done, frames_done, mon_wr, PPF);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [19:0] outs;
        request(2, 8'd1);
        wait_state(4'd2, 5, ok);
        tick();
        tick();
        #2;
        pc_image_req = 1'b1;
        rst_n = 1'b0;
        #1;
        outs = {state, frame_req_out, wr_reset, rd_reset, fifo_wr_en, busy, done,
                frames_done, overflow, timeout_err};
        n_checks++;
        if (!ok || outs !== 20'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_outputs: got %h want 0", outs);
        end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (state !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_held_req: state %0d busy %b want 0 0", state, busy);
        end
        pc_image_req = 1'b0;
        tick();
        request(2, 8'd1);
        n_checks++;
        if (state !== 4'd1 || wr_reset !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_rerequest: state %0d wr_reset %b want 1 1", state, wr_reset);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst();
        test_overflow();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
